// File: rtl/vigenere_decryption.sv
// Streaming Vigenere decrypter: one character in per cycle, decrypted character out one cycle later.
// Raw mode subtracts the key byte; alphabet mode rotates letters and passes other characters through.
module vigenere_decryption #(
    parameter int                   D_WIDTH    = 8,
    parameter int                   KEY_CHARS  = 4,
    parameter logic [D_WIDTH-1:0]   ALPHA_BASE = 8'h41,
    parameter int                   ALPHA_SIZE = 26,
    parameter logic [D_WIDTH-1:0]   TERM_CHAR  = 8'hFA
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [D_WIDTH-1:0]                data_i,
    input  logic                              valid_i,
    input  logic [KEY_CHARS*D_WIDTH-1:0]      key,
    input  logic [$clog2(KEY_CHARS):0]        key_len,
    input  logic                              mode,
    output logic                              busy,
    output logic [D_WIDTH-1:0]                data_o,
    output logic                              valid_o
);

    localparam int IDX_W = (KEY_CHARS > 1) ? $clog2(KEY_CHARS) : 1;
    localparam int LEN_W = $clog2(KEY_CHARS) + 1;
    localparam int KEY_W = KEY_CHARS * D_WIDTH;

    // Alphabet arithmetic is done one bit wider so base + size never overflows.
    localparam logic [D_WIDTH:0] BASE_X = {1'b0, ALPHA_BASE};
    localparam logic [D_WIDTH:0] SIZE_X = (D_WIDTH+1)'(ALPHA_SIZE);
    localparam logic [D_WIDTH:0] ONE_X  = (D_WIDTH+1)'(1);
    localparam logic [D_WIDTH:0] LAST_X = BASE_X + SIZE_X - ONE_X;
    localparam logic [LEN_W-1:0] MAXLEN = LEN_W'(KEY_CHARS);

    typedef enum logic [1:0] {
        IDLE,
        DECRYPT,
        FLUSH
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [KEY_W-1:0]     keyCap_q;
    logic [LEN_W-1:0]     lenCap_q;
    logic                 modeCap_q;
    logic [D_WIDTH-1:0]   dataOut_q;
    logic                 validOut_q;
    logic                 busy_q;

    logic [KEY_W-1:0]     selKey;
    logic [LEN_W-1:0]     selLen;
    logic                 selMode;
    logic [IDX_W-1:0]     selIdx;
    logic [LEN_W-1:0]     effLen;
    logic [D_WIDTH-1:0]   keyChar;
    logic [D_WIDTH:0]     keyX;
    logic [D_WIDTH:0]     dataX;
    logic                 keyInAlpha;
    logic                 dataInAlpha;
    logic [D_WIDTH:0]     shiftX;
    logic [D_WIDTH:0]     offX;
    logic [D_WIDTH:0]     rotX;
    logic [D_WIDTH:0]     sumX;
    logic                 advance;
    logic                 wrapIdx;
    logic                 isTerm;
    logic [D_WIDTH-1:0]   decData_d;
    logic [IDX_W-1:0]     idx_d;

    // In IDLE the first character is decrypted with the live key ports, since capture happens on that same edge.
    always_comb begin
        selKey  = keyCap_q;
        selLen  = lenCap_q;
        selMode = modeCap_q;
        selIdx  = idx_q;
        if (state_q == IDLE) begin
            selKey  = key;
            selLen  = key_len;
            selMode = mode;
            selIdx  = '0;
        end

        effLen = selLen;
        if (selLen == '0) begin
            effLen = LEN_W'(1);
        end else if (selLen > MAXLEN) begin
            effLen = MAXLEN;
        end

        keyChar     = selKey[int'(selIdx)*D_WIDTH +: D_WIDTH];
        keyX        = {1'b0, keyChar};
        dataX       = {1'b0, data_i};
        keyInAlpha  = (keyX >= BASE_X) && (keyX <= LAST_X);
        dataInAlpha = (dataX >= BASE_X) && (dataX <= LAST_X);
        shiftX      = keyInAlpha ? (keyX - BASE_X) : '0;
        offX        = dataX - BASE_X;
        rotX        = (offX >= shiftX) ? (offX - shiftX) : (offX + SIZE_X - shiftX);
        sumX        = BASE_X + rotX;

        if (selMode) begin
            decData_d = dataInAlpha ? sumX[D_WIDTH-1:0] : data_i;
            advance   = dataInAlpha;
        end else begin
            decData_d = data_i - keyChar;
            advance   = 1'b1;
        end

        wrapIdx = (LEN_W'(selIdx) == (effLen - LEN_W'(1)));
        idx_d   = selIdx;
        if (advance) begin
            idx_d = wrapIdx ? '0 : (selIdx + IDX_W'(1));
        end

        isTerm = (data_i == TERM_CHAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            keyCap_q   <= '0;
            lenCap_q   <= '0;
            modeCap_q  <= 1'b0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DECRYPT: begin
                    busy_q <= 1'b0;
                    if (valid_i && isTerm) begin
                        dataOut_q  <= TERM_CHAR;
                        validOut_q <= 1'b1;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= FLUSH;
                    end else if (valid_i) begin
                        dataOut_q  <= decData_d;
                        validOut_q <= 1'b1;
                        idx_q      <= idx_d;
                        state_q    <= DECRYPT;
                        if (state_q == IDLE) begin
                            keyCap_q  <= key;
                            lenCap_q  <= key_len;
                            modeCap_q <= mode;
                        end
                    end else begin
                        dataOut_q  <= '0;
                        validOut_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    dataOut_q  <= '0;
                    validOut_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    dataOut_q  <= '0;
                    validOut_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign data_o  = dataOut_q;
    assign valid_o = validOut_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_vigenere_decryption.sv
// Directed bench for vigenere_decryption; expected characters are hand-derived Vigenere results.
module tb_vigenere_decryption;

    logic        clk;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [31:0] key;
    logic [2:0]  key_len;
    logic        mode;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] KEY_KEY = {8'h00, 8'h59, 8'h45, 8'h4B};
    localparam logic [31:0] KEY_ZZZ = {8'h00, 8'h5A, 8'h5A, 8'h5A};
    localparam logic [31:0] KEY_AB  = {8'h00, 8'h00, 8'h42, 8'h41};
    localparam logic [31:0] KEY_RAW = {8'h00, 8'h00, 8'h01, 8'h03};

    vigenere_decryption dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key     (key),
        .key_len (key_len),
        .mode    (mode),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one input beat, let the DUT take it, then settle 1 ns past the edge so outputs can be read.
    task automatic applyStimulus(input logic [7:0] d, input logic v);
        data_i  = d;
        valid_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic closeMessage();
        applyStimulus(8'hFA, 1'b1);
        applyStimulus(8'h00, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h41, 1'b1);
        checks++;
        if ({valid_o, data_o, busy} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h busy=%b, expected 0/00/0", valid_o, data_o, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_alpha_hello();
        string inS  = "RIJVS";
        string expS = "HELLO";
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        for (int i = 0; i < inS.len(); i++) begin
            applyStimulus(inS[i], 1'b1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, expS[i]}) begin
                errors++;
                $display("[TB] FAIL alpha_hello[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expS[i]);
            end
        end
        closeMessage();
    endtask

    task automatic test_alpha_passthrough();
        string inS  = "RI JVS";
        string expS = "HE LLO";
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        for (int i = 0; i < inS.len(); i++) begin
            applyStimulus(inS[i], 1'b1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, expS[i]}) begin
                errors++;
                $display("[TB] FAIL alpha_space[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expS[i]);
            end
        end
        closeMessage();
    endtask

    task automatic test_raw_wrap();
        logic [7:0] inV  [3] = '{8'h02, 8'h00, 8'h10};
        logic [7:0] expV [3] = '{8'hFF, 8'hFF, 8'h0D};
        key = KEY_RAW; key_len = 3'd2; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(inV[i], 1'b1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, expV[i]}) begin
                errors++;
                $display("[TB] FAIL raw_wrap[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expV[i]);
            end
        end
        closeMessage();
    endtask

    // key_len = 0 behaves as a one-character key, so every byte uses key char 0 (0x03).
    task automatic test_keylen_zero();
        logic [7:0] inV  [3] = '{8'h05, 8'h06, 8'h01};
        logic [7:0] expV [3] = '{8'h02, 8'h03, 8'hFE};
        key = KEY_RAW; key_len = 3'd0; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(inV[i], 1'b1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, expV[i]}) begin
                errors++;
                $display("[TB] FAIL keylen_zero[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expV[i]);
            end
        end
        closeMessage();
    endtask

    task automatic test_gap();
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        applyStimulus(8'h52, 1'b1);
        applyStimulus(8'h49, 1'b0);
        checks++;
        if ({valid_o, data_o} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL gap_idle: got valid=%b data=%h, expected 0/00", valid_o, data_o);
        end
        applyStimulus(8'h49, 1'b1);
        checks++;
        if ({valid_o, data_o} !== {1'b1, 8'h45}) begin
            errors++;
            $display("[TB] FAIL gap_resume: got valid=%b data=%h, expected 1/45", valid_o, data_o);
        end
        closeMessage();
    endtask

    task automatic test_terminator();
        string expS = "HE";
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        applyStimulus(8'h52, 1'b1);
        checks++;
        if ({valid_o, data_o} !== {1'b1, expS[0]}) begin
            errors++;
            $display("[TB] FAIL term_pre0: got valid=%b data=%h, expected 1/%h", valid_o, data_o, expS[0]);
        end
        applyStimulus(8'h49, 1'b1);
        checks++;
        if ({valid_o, data_o} !== {1'b1, expS[1]}) begin
            errors++;
            $display("[TB] FAIL term_pre1: got valid=%b data=%h, expected 1/%h", valid_o, data_o, expS[1]);
        end
        applyStimulus(8'hFA, 1'b1);
        checks++;
        if ({valid_o, data_o, busy} !== {1'b1, 8'hFA, 1'b1}) begin
            errors++;
            $display("[TB] FAIL term_out: got valid=%b data=%h busy=%b, expected 1/fa/1", valid_o, data_o, busy);
        end
        applyStimulus(8'h52, 1'b1);
        checks++;
        if ({valid_o, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_drop: got valid=%b busy=%b, expected 0/0", valid_o, busy);
        end
    endtask

    // Runs straight after test_terminator: the new key must be sampled and the index restarted.
    task automatic test_back_to_back();
        string inS  = "BC";
        string expS = "BB";
        key = KEY_AB; key_len = 3'd2; mode = 1'b1;
        for (int i = 0; i < inS.len(); i++) begin
            applyStimulus(inS[i], 1'b1);
            checks++;
            if ({valid_o, data_o, busy} !== {1'b1, expS[i], 1'b0}) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got valid=%b data=%h busy=%b, expected 1/%h/0", i, valid_o, data_o, busy, expS[i]);
            end
        end
        closeMessage();
    endtask

    task automatic test_key_change();
        string inS  = "RIJVS";
        string expS = "HELLO";
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        for (int i = 0; i < inS.len(); i++) begin
            applyStimulus(inS[i], 1'b1);
            key = KEY_ZZZ; key_len = 3'd1; mode = 1'b0;
            checks++;
            if ({valid_o, data_o} !== {1'b1, expS[i]}) begin
                errors++;
                $display("[TB] FAIL key_change[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expS[i]);
            end
        end
        closeMessage();
    endtask

    task automatic test_mid_reset();
        string inS  = "RIJVS";
        string expS = "HELLO";
        key = KEY_KEY; key_len = 3'd3; mode = 1'b1;
        applyStimulus(8'h52, 1'b1);
        applyStimulus(8'h49, 1'b1);
        rst = 1'b1;
        applyStimulus(8'h4A, 1'b1);
        checks++;
        if ({valid_o, data_o, busy} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b data=%h busy=%b, expected 0/00/0", valid_o, data_o, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < inS.len(); i++) begin
            applyStimulus(inS[i], 1'b1);
            checks++;
            if ({valid_o, data_o} !== {1'b1, expS[i]}) begin
                errors++;
                $display("[TB] FAIL post_reset[%0d]: got valid=%b data=%h, expected 1/%h", i, valid_o, data_o, expS[i]);
            end
        end
        closeMessage();
    endtask

    initial begin
        rst = 1'b1; data_i = 8'h00; valid_i = 1'b0;
        key = '0; key_len = '0; mode = 1'b0;
        test_reset();
        test_alpha_hello();
        test_alpha_passthrough();
        test_raw_wrap();
        test_keylen_zero();
        test_gap();
        test_terminator();
        test_back_to_back();
        test_key_change();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vigenere_decryption.md
# vigenere_decryption

Streaming polyalphabetic (Vigenère) decrypter, the parametrised successor to the single-shift Caesar stage in the decryption pipeline. It consumes one encrypted character per cycle and emits the decrypted character one cycle later. The shift cycles through a multi-character key of run-time length. Two modes are supported: raw byte subtraction modulo 2^D_WIDTH, and alphabet-aware modular shifting that passes non-letters through unchanged. A terminator character closes each message; the key is re-sampled at the start of the next one.

## Interface
- D_WIDTH, 8: character width in bits.
- KEY_CHARS, 4: maximum key length in characters.
- ALPHA_BASE, 8'h41: first alphabet character ('A').
- ALPHA_SIZE, 26: alphabet size; must satisfy ALPHA_BASE + ALPHA_SIZE <= 2^D_WIDTH.
- TERM_CHAR, 8'hFA: end-of-message character.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- data_i  in  D_WIDTH  encrypted character.
- valid_i  in  1  data_i valid this cycle.
- key  in  KEY_CHARS*D_WIDTH  key characters; char j at key[j*D_WIDTH +: D_WIDTH]; char 0 is used first.
- key_len  in  $clog2(KEY_CHARS)+1  number of key characters in use.
- mode  in  1  0 = raw mode, 1 = alphabet mode.
- busy  out  1  high while the block is refusing input.
- data_o  out  D_WIDTH  decrypted character.
- valid_o  out  1  data_o valid this cycle.

## Operation
- States:
  - IDLE: no message is open.
  - DECRYPT: a message is open.
  - FLUSH: one cycle after each terminator.
- Start of message (IDLE, valid_i=1, data_i != TERM_CHAR):
  - Capture key, key_len and mode into internal registers.
  - Set key index to 0, then process the character as in DECRYPT.
  - Go to DECRYPT.
- Captured values are held for the whole message; changes on the key, key_len or mode ports mid-message are ignored.
- Effective length L = key_len clamped to the range 1..KEY_CHARS (key_len=0 is treated as 1).
- Raw mode:
  - data_o = data_i - key_char[idx], truncated to D_WIDTH bits (wraps).
  - Index advances on every non-terminator character.
- Alphabet mode:
  - shift = key_char - ALPHA_BASE if key_char is in the alphabet, else 0.
  - If data_i is in [ALPHA_BASE, ALPHA_BASE+ALPHA_SIZE-1]:
    - off = data_i - ALPHA_BASE.
    - data_o = ALPHA_BASE + (off >= shift ? off - shift : off + ALPHA_SIZE - shift).
    - Index advances.
  - Otherwise: data_o = data_i and the index does not advance.
- Index advance: idx <= (idx == L-1) ? 0 : idx+1.
- Terminator (valid_i=1, data_i == TERM_CHAR, in IDLE or DECRYPT):
  - Forward TERM_CHAR unchanged with valid_o=1.
  - Reset index to 0 and go to FLUSH.
- FLUSH: busy=1 and all input is dropped (no valid_o results from it); go to IDLE next cycle.
- Cycles with valid_i=0: valid_o=0 and data_o=0 on the next cycle; state and index hold.

## Timing
- Reset, applied on the clk edge with rst=1:
  - busy=0, valid_o=0, data_o=0.
  - State IDLE, index 0, captured key/len/mode cleared.
  - Reset has priority over all other events, including mid-message and during FLUSH.
- Latency: exactly 1 cycle from valid_i to valid_o; throughput 1 character/cycle.
- busy is registered. It is high for exactly the cycle after the edge that accepted a terminator, i.e. the same cycle in which valid_o carries TERM_CHAR.
- valid_i asserted while busy=1 is lost; the upstream stage must hold it off.
- Back-to-back messages: the first valid character after FLUSH re-samples the key ports.
- Index wrap to 0 is applied in the same cycle as the character that used key char L-1.

## Test plan
- Alphabet mode, key="KEY" (0x4B,0x45,0x59), key_len=3, input "RIJVS" -> "HELLO" on consecutive cycles, each 1 cycle after its input.
- Alphabet mode, same key, input "RI JVS" -> "HE LLO"; the space passes through and does not advance the key index.
- Raw mode, key chars 0x03,0x01, key_len=2, input 0x02,0x00,0x10 -> 0xFF,0xFF,0x0D (wrap-around).
- Terminator: "RI" then 0xFA -> "HE", then 0xFA with busy=1. A valid_i pulse during busy produces no output. Next message with key="AB" (key_len=2), input "BC" -> "BB", confirming the key was re-sampled and the index restarted.
- Key ports changed mid-message (key "KEY" -> "ZZZ" after the first character): output still "HELLO".
- rst=1 after 2 characters of a message -> next cycle valid_o=0, data_o=0, busy=0. A new message then decrypts starting from key char 0.
